// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: stall/flush controller for the 5-stage MIPS core.
// Sequences the variable-latency data-memory handshake for the EX/MEM
// instruction, freezes the front pipeline while the access is outstanding,
// inserts MEM/WB bubbles, latches load data and detects load-use hazards.
// Optional stall-cycle counter enabled by defining MEM_STALL_CNT_EN.
module mem_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        ID_EX_MemRead_i,
    input  logic [4:0]  ID_EX_Rt_i,
    input  logic [4:0]  IF_ID_Rs_i,
    input  logic [4:0]  IF_ID_Rt_i,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        dmem_req_o,
    output logic [31:0] mdr_o,
    output logic        stall_all_o,
    output logic        lu_hold_o,
    output logic        idex_flush_o,
    output logic        wb_bubble_o,
    output logic        err_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

    // Last wait count before the access is declared lost.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             req_nxt;
    logic             err_nxt;
    logic             mdr_en;
    logic             stall;
    logic             mem_op;
    logic             lu;

    assign mem_op = MemRead_i | MemWrite_i;

    // Next-state and handshake decode; defaults hold the current values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = dmem_req_o;
        err_nxt   = err_o;
        mdr_en    = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = mem_op;
                if (mem_op) begin
                    state_nxt = WAIT;
                    req_nxt   = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            WAIT: begin
                stall   = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (dmem_ack_i) begin
                    state_nxt = DONE;
                    req_nxt   = 1'b0;
                    mdr_en    = MemRead_i;
                end else if (cnt == LAST) begin
                    state_nxt = ERR;
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                end
            end
            // One free cycle so MEM/WB captures the result; never re-issue.
            DONE: state_nxt = IDLE;
            ERR: begin
                stall   = 1'b1;
                err_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, wait counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_req_o <= 1'b0;
            mdr_o      <= '0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dmem_req_o <= req_nxt;
            err_o      <= err_nxt;
            if (mdr_en) begin
                mdr_o <= dmem_rdata_i;
            end
        end
    end

    // Load-use hazard; deferred while the memory stall freezes the pipe.
    assign lu = ID_EX_MemRead_i && (ID_EX_Rt_i != 5'd0) &&
                ((ID_EX_Rt_i == IF_ID_Rs_i) || (ID_EX_Rt_i == IF_ID_Rt_i));

    assign stall_all_o  = stall & ~rst_i;
    assign wb_bubble_o  = stall_all_o;
    assign lu_hold_o    = lu & ~stall_all_o & ~rst_i;
    assign idex_flush_o = lu_hold_o;

`ifdef MEM_STALL_CNT_EN
    logic [31:0] scnt;

    // Saturating count of every frozen or load-use held cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scnt <= '0;
        end else if ((stall_all_o || lu_hold_o) && (scnt != 32'hFFFF_FFFF)) begin
            scnt <= scnt + 32'd1;
        end
    end

    assign stall_cnt_o = scnt;
`else
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Testbench for mem_stall_ctrl (TIMEOUT=4): directed scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_mem_stall_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        idex_mem_read = 1'b0;
    logic [4:0]  idex_rt = 5'd0;
    logic [4:0]  ifid_rs = 5'd0;
    logic [4:0]  ifid_rt = 5'd0;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        req;
    logic [31:0] mdr;
    logic        stall_all;
    logic        lu_hold;
    logic        idex_flush;
    logic        wb_bubble;
    logic        err;
    logic [31:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    mem_stall_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .MemRead_i(mem_read), .MemWrite_i(mem_write),
        .ID_EX_MemRead_i(idex_mem_read), .ID_EX_Rt_i(idex_rt),
        .IF_ID_Rs_i(ifid_rs), .IF_ID_Rt_i(ifid_rt),
        .dmem_ack_i(ack), .dmem_rdata_i(rdata),
        .dmem_req_o(req), .mdr_o(mdr), .stall_all_o(stall_all),
        .lu_hold_o(lu_hold), .idex_flush_o(idex_flush),
        .wb_bubble_o(wb_bubble), .err_o(err), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: an access is either outstanding (busy, with the
    // number of cycles already waited), just completed, or lost for good.
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    int          m_waited = 0;
    logic [31:0] m_mdr = 32'h0;
    longint      m_cnt = 0;

    function automatic bit exp_stall();
        if (rst) return 0;
        return m_err || m_busy || (!m_done && (mem_read || mem_write));
    endfunction

    function automatic bit exp_lu();
        bit hz;
        hz = idex_mem_read && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        return !rst && hz && !exp_stall();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_waited = 0;
            m_mdr = 32'h0; m_cnt = 0;
        end else begin
            if ((exp_stall() || exp_lu()) && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_err) begin
                m_err = 1;
            end else if (m_busy) begin
                if (ack) begin
                    m_busy = 0; m_done = 1;
                    if (mem_read) m_mdr = rdata;
                end else if (m_waited + 1 == TO) begin
                    m_busy = 0; m_err = 1;
                end else begin
                    m_waited++;
                end
            end else if (m_done) begin
                m_done = 0;
            end else if (mem_read || mem_write) begin
                m_busy = 1; m_waited = 0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; ack = 0; rdata = 32'h0;
        idex_mem_read = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    endtask

    task automatic test_reset();
        rst = 1; mem_read = 1; ack = 1; rdata = 32'h1234_5678;
        idex_mem_read = 1; idex_rt = 5'd3; ifid_rs = 5'd3;
        nxt(); nxt();
        @(negedge clk);
        vectors++;
        if ({stall_all, lu_hold, idex_flush, wb_bubble, req, err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {stall_all, lu_hold, idex_flush, wb_bubble, req, err});
        end
        vectors++;
        if (mdr !== 32'h0 || stall_cnt !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_regs: mdr=%h cnt=%h want 0/0", mdr, stall_cnt);
        end
        clear_inputs();
        rst = 0;
        nxt();
    endtask

    task automatic test_load();
        mem_read = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin ack = 1; rdata = 32'hDEAD_BEEF; end
            @(negedge clk);
            vectors++;
            if (stall_all !== 1'b1 || wb_bubble !== 1'b1 || req !== (i > 0)) begin
                miscompares++;
                $display("FAIL load_stall[%0d]: stall=%b bubble=%b req=%b want 1 1 %b",
                         i, stall_all, wb_bubble, req, i > 0);
            end
            nxt();
        end
        ack = 0; rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        vectors++;
        if (stall_all !== 0 || wb_bubble !== 0 || req !== 0 || mdr !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL load_done: stall=%b bubble=%b req=%b mdr=%h want 0 0 0 deadbeef",
                     stall_all, wb_bubble, req, mdr);
        end
        mem_read = 0;
        nxt();
    endtask

    task automatic test_store();
        mem_write = 1;
        @(negedge clk);
        vectors++;
        if (stall_all !== 1 || req !== 0) begin
            miscompares++;
            $display("FAIL store_detect: stall=%b req=%b want 1 0", stall_all, req);
        end
        nxt();
        ack = 1; rdata = 32'h1234_5678;
        @(negedge clk);
        vectors++;
        if (stall_all !== 1 || req !== 1) begin
            miscompares++;
            $display("FAIL store_wait: stall=%b req=%b want 1 1", stall_all, req);
        end
        nxt();
        ack = 0;
        @(negedge clk);
        vectors++;
        if (stall_all !== 0 || req !== 0 || mdr !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL store_done: stall=%b req=%b mdr=%h want 0 0 deadbeef",
                     stall_all, req, mdr);
        end
        nxt();
        @(negedge clk);
        vectors++;
        if (stall_all !== 1 || req !== 0) begin
            miscompares++;
            $display("FAIL store_no_reissue: stall=%b req=%b want 1 0", stall_all, req);
        end
        mem_write = 0;
        nxt();
        @(negedge clk);
        vectors++;
        if (stall_all !== 0 || req !== 0) begin
            miscompares++;
            $display("FAIL store_idle: stall=%b req=%b want 0 0", stall_all, req);
        end
    endtask

    task automatic test_load_use();
        idex_mem_read = 1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7;
        #1;
        vectors++;
        if ({lu_hold, idex_flush, stall_all} !== 3'b110) begin
            miscompares++;
            $display("FAIL load_use_hit: got %b want 110", {lu_hold, idex_flush, stall_all});
        end
        ifid_rs = 5'd9; ifid_rt = 5'd5;
        #1;
        vectors++;
        if ({lu_hold, idex_flush, stall_all} !== 3'b110) begin
            miscompares++;
            $display("FAIL load_use_rt: got %b want 110", {lu_hold, idex_flush, stall_all});
        end
        idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        #1;
        vectors++;
        if ({lu_hold, idex_flush, stall_all} !== 3'b000) begin
            miscompares++;
            $display("FAIL load_use_r0: got %b want 000", {lu_hold, idex_flush, stall_all});
        end
        clear_inputs();
        nxt();
    endtask

    task automatic test_simultaneous();
        idex_mem_read = 1; idex_rt = 5'd8; ifid_rt = 5'd8; mem_read = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin ack = 1; rdata = 32'hCAFE_F00D; end
            @(negedge clk);
            vectors++;
            if (lu_hold !== 0 || idex_flush !== 0 || stall_all !== 1) begin
                miscompares++;
                $display("FAIL simul_defer[%0d]: lu=%b flush=%b stall=%b want 0 0 1",
                         i, lu_hold, idex_flush, stall_all);
            end
            nxt();
        end
        ack = 0;
        @(negedge clk);
        vectors++;
        if (lu_hold !== 1 || idex_flush !== 1 || mdr !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL simul_done: lu=%b flush=%b mdr=%h want 1 1 cafef00d",
                     lu_hold, idex_flush, mdr);
        end
        clear_inputs();
        nxt();
    endtask

    task automatic test_timeout();
        mem_read = 1;
        nxt();
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            vectors++;
            if (err !== 0 || req !== 1) begin
                miscompares++;
                $display("FAIL timeout_wait[%0d]: err=%b req=%b want 0 1", i, err, req);
            end
            nxt();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (err !== 1 || stall_all !== 1 || wb_bubble !== 1 || req !== 0) begin
                miscompares++;
                $display("FAIL timeout_err[%0d]: err=%b stall=%b bubble=%b req=%b want 1 1 1 0",
                         i, err, stall_all, wb_bubble, req);
            end
            nxt();
        end
        rst = 1;
        #1;
        vectors++;
        if (stall_all !== 0 || wb_bubble !== 0) begin
            miscompares++;
            $display("FAIL timeout_rst_comb: stall=%b bubble=%b want 0 0", stall_all, wb_bubble);
        end
        nxt();
        rst = 0; mem_read = 0; ack = 1; rdata = 32'hFFFF_0000;
        @(negedge clk);
        vectors++;
        if (err !== 0 || req !== 0 || stall_all !== 0 || mdr !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout_cleared: err=%b req=%b stall=%b mdr=%h want 0 0 0 0",
                     err, req, stall_all, mdr);
        end
        nxt();
        ack = 0;
        @(negedge clk);
        vectors++;
        if (err !== 0 || req !== 0 || mdr !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout_late_ack: err=%b req=%b mdr=%h want 0 0 0", err, req, mdr);
        end
    endtask

    task automatic test_stall_cnt();
        logic [31:0] want;
        rst = 1; clear_inputs();
        nxt();
        rst = 0;
        mem_read = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin ack = 1; rdata = 32'h5555_AAAA; end
            nxt();
        end
        ack = 0; mem_read = 0;
        nxt();
        idex_mem_read = 1; idex_rt = 5'd5; ifid_rs = 5'd5;
        nxt();
        clear_inputs();
`ifdef MEM_STALL_CNT_EN
        want = 32'd5;
`else
        want = 32'd0;
`endif
        @(negedge clk);
        vectors++;
        if (stall_cnt !== want) begin
            miscompares++;
            $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, want);
        end
        nxt();
    endtask

    task automatic test_random();
        logic [31:0] want_cnt;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            mem_read = ($urandom_range(0, 2) == 0);
            mem_write = !mem_read && ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 2) == 0);
            rdata = $urandom;
            idex_mem_read = $urandom_range(0, 1);
            idex_rt = 5'($urandom_range(0, 3));
            ifid_rs = 5'($urandom_range(0, 3));
            ifid_rt = 5'($urandom_range(0, 3));
            @(negedge clk);
`ifdef MEM_STALL_CNT_EN
            want_cnt = 32'(m_cnt);
`else
            want_cnt = 32'd0;
`endif
            vectors++;
            if (stall_all !== exp_stall() || wb_bubble !== exp_stall() ||
                lu_hold !== exp_lu() || idex_flush !== exp_lu()) begin
                miscompares++;
                $display("FAIL rand_comb[%0d]: stall=%b bubble=%b lu=%b flush=%b want %b %b %b %b",
                         n, stall_all, wb_bubble, lu_hold, idex_flush,
                         exp_stall(), exp_stall(), exp_lu(), exp_lu());
            end
            vectors++;
            if (req !== m_busy || err !== m_err || mdr !== m_mdr || stall_cnt !== want_cnt) begin
                miscompares++;
                $display("FAIL rand_regs[%0d]: req=%b err=%b mdr=%h cnt=%0d want %b %b %h %0d",
                         n, req, err, mdr, stall_cnt, m_busy, m_err, m_mdr, want_cnt);
            end
            nxt();
        end
        rst = 1; clear_inputs();
        nxt();
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        test_reset();
        test_load();
        test_store();
        test_load_use();
        test_simultaneous();
        test_timeout();
        test_stall_cnt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- Pipeline stall/flush controller for the 5-stage MIPS core.
- Sequences the variable-latency data-memory handshake for the instruction in EX/MEM, and freezes the front pipeline registers while the access is outstanding.
- Feeds bubbles into MEM/WB so no register write is duplicated, and latches read data for MEM/WB.
- Also detects load-use hazards between ID/EX and IF/ID.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before error. Legal range 2..255.
- CNT_W, 8: width of the internal wait counter.

Ports:
- clk_i, input, 1: clock; all state updates on posedge.
- rst_i, input, 1: synchronous, active-high reset.
- MemRead_i, input, 1: EX/MEM MemRead control.
- MemWrite_i, input, 1: EX/MEM MemWrite control.
- ID_EX_MemRead_i, input, 1: ID/EX MemRead control.
- ID_EX_Rt_i, input, 5: ID/EX destination of the load.
- IF_ID_Rs_i, input, 5: IF/ID source register Rs.
- IF_ID_Rt_i, input, 5: IF/ID source register Rt.
- dmem_ack_i, input, 1: data memory completion strobe.
- dmem_rdata_i, input, 32: memory read data; valid only when dmem_ack_i=1.
- dmem_req_o, output, 1: registered memory request.
- mdr_o, output, 32: latched read data to MEM/WB mdr_i.
- stall_all_o, output, 1: hold PC, IF/ID, ID/EX, EX/MEM.
- lu_hold_o, output, 1: hold PC and IF/ID (load-use).
- idex_flush_o, output, 1: zero ID/EX control fields.
- wb_bubble_o, output, 1: force MEM/WB RegWr_i=0.
- err_o, output, 1: sticky memory timeout flag.
- stall_cnt_o, output, 32: stall-cycle count (see Optional Feature).

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous, active-high.
- While rst_i=1 at a posedge:
  - state <- IDLE, wait count <- 0.
  - dmem_req_o <- 0, mdr_o <- 0, err_o <- 0, stall_cnt_o <- 0.
  - All combinational hold/flush outputs are forced to 0 while rst_i=1.
- mem_op = MemRead_i | MemWrite_i.
- FSM states: IDLE, WAIT, DONE, ERR.
  - IDLE:
    - stall_all_o = mem_op.
    - If mem_op: next state WAIT, dmem_req_o <- 1, count <- 0.
  - WAIT:
    - stall_all_o = 1, dmem_req_o held 1, count increments each cycle.
    - If dmem_ack_i: mdr_o <- dmem_rdata_i (loads only; writes leave mdr_o unchanged), dmem_req_o <- 0, next state DONE.
    - Else if count == TIMEOUT-1: next state ERR, err_o <- 1, dmem_req_o <- 0.
  - DONE:
    - stall_all_o = 0, so the pipeline advances and MEM/WB captures mdr_o.
    - Next state IDLE unconditionally, even if mem_op is still high. This prevents re-issuing the same instruction.
  - ERR:
    - stall_all_o = 1, wb_bubble_o = 1, err_o = 1.
    - Leaves only via rst_i.
- Minimum memory stall is 2 cycles (the IDLE detect cycle plus the WAIT ack cycle). mdr_o is valid from the DONE cycle onward.
- dmem_ack_i seen outside WAIT is ignored.
- wb_bubble_o = stall_all_o. Every frozen cycle inserts a non-writing bubble into MEM/WB.
- Load-use hazard:
  - lu = ID_EX_MemRead_i & (ID_EX_Rt_i != 0) & ((ID_EX_Rt_i == IF_ID_Rs_i) | (ID_EX_Rt_i == IF_ID_Rt_i)).
  - lu_hold_o = lu & ~stall_all_o.
  - idex_flush_o = lu & ~stall_all_o.
- Priority: the memory stall dominates. When stall_all_o=1, the load-use hazard is deferred (lu_hold_o=0, idex_flush_o=0) and is re-evaluated once the pipeline unfreezes.
- Reset mid-WAIT: dmem_req_o is 0 from the cycle after the reset edge; any in-flight ack is ignored.

Optional Feature:
- Macro: MEM_STALL_CNT_EN.
- Defined:
  - stall_cnt_o increments by 1 on every posedge where rst_i=0 and (stall_all_o | lu_hold_o)=1.
  - It saturates at 32'hFFFFFFFF and resets to 0.
- Undefined: stall_cnt_o is tied to 32'h0 and no counter logic is present. The port exists in both builds.

Test Plan:
1. Load with ack on the 3rd WAIT cycle:
   - Stimulus: MemRead_i=1 in IDLE, dmem_rdata_i=32'hDEADBEEF with the ack.
   - Required: stall_all_o=1 for 4 cycles, dmem_req_o=1 for 3 cycles, mdr_o=32'hDEADBEEF in DONE, wb_bubble_o=1 exactly during the stall.
2. Store with immediate ack:
   - Stimulus: MemWrite_i=1, ack in the first WAIT cycle.
   - Required: 2 stall cycles, then DONE; mdr_o unchanged; FSM returns to IDLE though MemWrite_i is still 1 in DONE.
3. Load-use hazard:
   - Stimulus: ID_EX_MemRead_i=1, ID_EX_Rt_i=5, IF_ID_Rs_i=5, no mem_op.
   - Required: lu_hold_o=1, idex_flush_o=1, stall_all_o=0.
   - Repeat with ID_EX_Rt_i=0: all three outputs are 0.
4. Simultaneous hazards:
   - Stimulus: load-use condition true while the FSM is in WAIT.
   - Required: lu_hold_o=0 and idex_flush_o=0 until DONE, then lu_hold_o=1.
5. Timeout:
   - Stimulus: TIMEOUT=4, MemRead_i=1, never ack.
   - Required: err_o=1 after 4 WAIT cycles, stall_all_o stays 1. rst_i for 1 cycle clears all state; a late ack after reset has no effect.
6. MEM_STALL_CNT_EN defined:
   - Stimulus: scenario 1 followed by scenario 3.
   - Required: stall_cnt_o=5. With the macro undefined, stall_cnt_o=0.
